tow_round_ctrl: RTL and testbench

//  Round sequencer for Tug of War reaction rounds; sits between the slow-tick divider, the LFSR and the player buttons.
//  - Gates the LFSR shift enable and collects DLY_BITS serial random bits.
//  - Waits BASE_DLY+random ticks, lights GO and awards the round to the first press after GO.
//  - Flags any press before GO as a foul.

---
 rtl/tow_round_ctrl.sv | 162 ++++++++++++++++
 tb/tb_tow_round_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tow_round_ctrl.sv
// Tug of War round sequencer: seeds a random delay from the LFSR,
// lights GO, then judges wins, ties, fouls and timeouts.
// Optional macro: TOW_LFSR_FREERUN_EN (LFSR shifts on every tick).
// Ports: clk, rst (async, active-low), tick, start, rout,
//   btn_l, btn_r -> lfsr_en, go, busy, win_l, win_r, foul_l, foul_r
module tow_round_ctrl #(
  parameter int DLY_BITS = 4,
  parameter int BASE_DLY = 8,
  parameter int GO_TMO   = 32,
  parameter int HOLD     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic start,
  input  logic rout,
  input  logic btn_l,
  input  logic btn_r,
  output logic lfsr_en,
  output logic go,
  output logic busy,
  output logic win_l,
  output logic win_r,
  output logic foul_l,
  output logic foul_r
);

  // Counter must hold the longest of the wait, GO and hold intervals.
  localparam int MAXD = BASE_DLY + (1 << DLY_BITS) - 1;
  localparam int M1   = (MAXD > GO_TMO) ? MAXD : GO_TMO;
  localparam int MAXV = (M1 > HOLD) ? M1 : HOLD;
  localparam int CW0  = $clog2(MAXV + 1);
  localparam int CW   = (CW0 > DLY_BITS + 1) ? CW0 : DLY_BITS + 1;
  localparam int BW   = $clog2(DLY_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [DLY_BITS-1:0] r_rnd;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bitcnt;
  logic                r_go;
  logic                r_win_l;
  logic                r_win_r;
  logic                r_foul_l;
  logic                r_foul_r;

  logic [DLY_BITS-1:0] w_rnd_nxt;
  logic [CW-1:0]       w_dly;
  logic                w_press;
  logic                w_last;

  assign w_rnd_nxt = {r_rnd[DLY_BITS-2:0], rout};
  assign w_dly     = CW'(BASE_DLY)
                   + {{(CW-DLY_BITS){1'b0}}, w_rnd_nxt};
  assign w_press   = btn_l | btn_r;
  assign w_last    = (r_cnt == CW'(1));

`ifdef TOW_LFSR_FREERUN_EN
  assign lfsr_en = tick;
`else
  assign lfsr_en = tick & (r_state == S_SEED);
`endif

  assign go     = r_go;
  assign busy   = (r_state != S_IDLE);
  assign win_l  = r_win_l;
  assign win_r  = r_win_r;
  assign foul_l = r_foul_l;
  assign foul_r = r_foul_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_rnd    <= '0;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_go     <= 1'b0;
      r_win_l  <= 1'b0;
      r_win_r  <= 1'b0;
      r_foul_l <= 1'b0;
      r_foul_r <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SEED;
            r_bitcnt <= '0;
            r_win_l  <= 1'b0;
            r_win_r  <= 1'b0;
            r_foul_l <= 1'b0;
            r_foul_r <= 1'b0;
          end
        end
        S_SEED: begin
          if (tick) begin
            r_rnd    <= w_rnd_nxt;
            r_bitcnt <= r_bitcnt + BW'(1);
            if (r_bitcnt == BW'(DLY_BITS - 1)) begin
              r_cnt   <= w_dly;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_press) begin
            r_foul_l <= btn_l;
            r_foul_r <= btn_r;
            r_cnt    <= CW'(HOLD);
            r_state  <= S_DONE;
          end else if (tick) begin
            if (w_last) begin
              r_go    <= 1'b1;
              r_cnt   <= CW'(GO_TMO);
              r_state <= S_GO;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_GO: begin
          if (w_press) begin
            r_win_l <= btn_l;
            r_win_r <= btn_r;
            r_go    <= 1'b0;
            r_cnt   <= CW'(HOLD);
            r_state <= S_DONE;
          end else if (tick) begin
            if (w_last) begin
              r_go    <= 1'b0;
              r_cnt   <= CW'(HOLD);
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_DONE: begin
          if (tick) begin
            if (w_last) begin
              r_win_l  <= 1'b0;
              r_win_r  <= 1'b0;
              r_foul_l <= 1'b0;
              r_foul_r <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Directed bench for tow_round_ctrl: delay, win, tie, foul,
// timeout, start-while-busy and mid-round reset.
module tb_tow_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic rout = 1'b0;
  logic btn_l = 1'b0;
  logic btn_r = 1'b0;
  logic lfsr_en, go, busy;
  logic win_l, win_r, foul_l, foul_r;

  int errs = 0;
  int checks = 0;
  int n_en = 0;

  always #5 clk = ~clk;

  tow_round_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .start(start), .rout(rout),
    .btn_l(btn_l), .btn_r(btn_r),
    .lfsr_en(lfsr_en), .go(go), .busy(busy),
    .win_l(win_l), .win_r(win_r),
    .foul_l(foul_l), .foul_r(foul_r)
  );

  task automatic chk(input string tag,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(negedge clk);
    tick = 1'b1;
    #1;
    if (lfsr_en) n_en++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tks(input int n);
    for (int i = 0; i < n; i++) tk();
  endtask

  task automatic pstart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic l, input logic r);
    @(negedge clk);
    btn_l = l;
    btn_r = r;
    @(negedge clk);
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic seed(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) begin
      rout = b[i];
      tk();
    end
    rout = 1'b0;
  endtask

  task automatic flags(input string tag, input logic wl,
                       input logic wr, input logic fl,
                       input logic fr);
    chk({tag, "_win_l"}, win_l, wl);
    chk({tag, "_win_r"}, win_r, wr);
    chk({tag, "_foul_l"}, foul_l, fl);
    chk({tag, "_foul_r"}, foul_r, fr);
  endtask

  initial begin
    logic fr_exp;
`ifdef TOW_LFSR_FREERUN_EN
    fr_exp = 1'b1;
`else
    fr_exp = 1'b0;
`endif
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_go", go, 1'b0);
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // idle: buttons ignored, lfsr_en behaviour
    press(1'b1, 1'b1);
    chk("idle_busy", busy, 1'b0);
    flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick = 1'b1;
    #1;
    chk("idle_lfsr_en", lfsr_en, fr_exp);
    @(negedge clk);
    tick = 1'b0;

    // delay round: rnd=1011 -> go after 19 ticks, then left wins
    pstart();
    chk("seed_busy", busy, 1'b1);
    n_en = 0;
    seed(4'b1011);
    chkn("seed_en_cnt", n_en, 4);
    tks(18);
    chk("wait18_go", go, 1'b0);
    tk();
    chk("wait19_go", go, 1'b1);
    chkn("wait_en_cnt", n_en, fr_exp ? 23 : 4);
    pstart();
    chk("busy_start_go", go, 1'b1);
    chk("busy_start_busy", busy, 1'b1);
    press(1'b1, 1'b0);
    chk("win_go", go, 1'b0);
    flags("win", 1'b1, 1'b0, 1'b0, 1'b0);
    tks(15);
    chk("win_hold_busy", busy, 1'b1);
    chk("win_hold_flag", win_l, 1'b1);
    tk();
    chk("win_idle_busy", busy, 1'b0);
    chk("win_idle_flag", win_l, 1'b0);

    // tie: rnd=0 -> go after 8 ticks
    pstart();
    seed(4'b0000);
    tks(7);
    chk("tie7_go", go, 1'b0);
    tk();
    chk("tie8_go", go, 1'b1);
    press(1'b1, 1'b1);
    chk("tie_go", go, 1'b0);
    flags("tie", 1'b1, 1'b1, 1'b0, 1'b0);
    tks(16);
    chk("tie_idle", busy, 1'b0);

    // foul: btn_r with WAIT tick 5, press beats the tick
    pstart();
    seed(4'b1111);
    tks(4);
    @(negedge clk);
    tick = 1'b1;
    btn_r = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    btn_r = 1'b0;
    chk("foul_go", go, 1'b0);
    flags("foul", 1'b0, 1'b0, 1'b0, 1'b1);
    tks(15);
    chk("foul_hold_busy", busy, 1'b1);
    chk("foul_hold_go", go, 1'b0);
    chk("foul_hold_flag", foul_r, 1'b1);
    tk();
    chk("foul_idle", busy, 1'b0);
    chk("foul_clr", foul_r, 1'b0);

    // timeout: no press for 32 ticks after go
    pstart();
    seed(4'b0000);
    tks(8);
    chk("tmo_go_on", go, 1'b1);
    tks(31);
    chk("tmo31_go", go, 1'b1);
    tk();
    chk("tmo32_go", go, 1'b0);
    chk("tmo_busy", busy, 1'b1);
    flags("tmo", 1'b0, 1'b0, 1'b0, 1'b0);
    tks(15);
    chk("tmo_hold", busy, 1'b1);
    tk();
    chk("tmo_idle", busy, 1'b0);

    // async reset mid-WAIT, then restart at SEED
    pstart();
    seed(4'b0101);
    tks(3);
    chk("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_go", go, 1'b0);
    flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    pstart();
    chk("restart_busy", busy, 1'b1);
    n_en = 0;
    tk();
    chkn("restart_seed_en", n_en, 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
